// File: rtl/multi_mode_shift_counter_pkg.sv
// multi_mode_shift_counter_pkg: mode and direction encodings shared by the counter and its decoder
package multi_mode_shift_counter_pkg;
   typedef enum logic {MODE_JOHNSON = 1'b0, MODE_RING = 1'b1} mode_t;
   typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;
endpackage

// File: rtl/multi_mode_shift_counter_shift_state_decode.sv
// shift_state_decode: sequence position and legality of a Johnson or ring counter value
module shift_state_decode
   import multi_mode_shift_counter_pkg::*;
#(
   parameter int WIDTH = 4,
   localparam int IDXW = $clog2(2 * WIDTH)
) (
   input  logic [WIDTH-1:0] q,
   input  logic             mode,
   output logic [IDXW-1:0]  index,
   output logic             legal
);
   int pc;
   int tr;
   logic [IDXW-1:0] pos;
   always_comb begin
      pc = $countones(q);
      tr = $countones(q[WIDTH-2:0] ^ q[WIDTH-1:1]);
      pos = '0;
      for (int i = 0; i < WIDTH; i++)
         if (q[i]) pos = IDXW'(i);
      legal = mode == MODE_RING ? pc == 1 : tr <= 1;
      index = !legal ? '0 : mode == MODE_RING ? pos : IDXW'(q[0] ? pc : (2 * WIDTH - pc) % (2 * WIDTH));
   end
endmodule

// File: rtl/multi_mode_shift_counter.sv
// multi_mode_shift_counter: Johnson/ring shift counter with load, direction control and self-correction
module multi_mode_shift_counter
   import multi_mode_shift_counter_pkg::*;
#(
   parameter int WIDTH = 4,
   localparam int IDXW = $clog2(2 * WIDTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             mode,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] q,
   output logic [IDXW-1:0]  index,
   output logic             wrap,
   output logic             illegal
);
   logic mode_q;
   logic mode_next;
   logic legal;
   logic load_legal;
   logic [IDXW-1:0] unused_load_index;
   logic [IDXW-1:0] max_idx;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] up;
   logic [WIDTH-1:0] down;
   logic wrap_next;
   logic illegal_next;

   function automatic logic [WIDTH-1:0] seed(input logic m);
      return m == MODE_RING ? WIDTH'(1) : '0;
   endfunction

   // q is decoded against the registered mode; load_value against the mode it will be loaded under
   shift_state_decode #(.WIDTH(WIDTH)) q_decode (
      .q(q), .mode(mode_q), .index(index), .legal(legal)
   );
   shift_state_decode #(.WIDTH(WIDTH)) load_decode (
      .q(load_value), .mode(mode), .index(unused_load_index), .legal(load_legal)
   );

   always_comb begin
      up = mode_q == MODE_RING ? {q[WIDTH-2:0], q[WIDTH-1]} : {q[WIDTH-2:0], ~q[WIDTH-1]};
      down = mode_q == MODE_RING ? {q[0], q[WIDTH-1:1]} : {~q[0], q[WIDTH-1:1]};
      max_idx = mode_q == MODE_RING ? IDXW'(WIDTH - 1) : IDXW'(2 * WIDTH - 1);
      q_next = q;
      mode_next = mode_q;
      wrap_next = 1'b0;
      illegal_next = 1'b0;
      if (load) begin
         mode_next = mode;
         q_next = load_legal ? load_value : seed(mode);
         illegal_next = !load_legal;
      end else if (mode != mode_q) begin
         mode_next = mode;
         q_next = seed(mode);
      end else if (enable && !legal) begin
         q_next = seed(mode_q);
         illegal_next = 1'b1;
      end else if (enable) begin
         q_next = dir == DIR_DOWN ? down : up;
         wrap_next = dir == DIR_DOWN ? index == '0 : index == max_idx;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         q <= seed(mode);
         mode_q <= mode;
         wrap <= 1'b0;
         illegal <= 1'b0;
      end else begin
         q <= q_next;
         mode_q <= mode_next;
         wrap <= wrap_next;
         illegal <= illegal_next;
      end
   end
endmodule

// File: tb/tb_multi_mode_shift_counter.sv
// tb_multi_mode_shift_counter: directed and randomized checks against a sequence-table model of the counter
module tb_multi_mode_shift_counter;
   localparam int W = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic enable = 1'b0;
   logic mode = 1'b0;
   logic dir = 1'b0;
   logic load = 1'b0;
   logic [W-1:0] load_value = '0;
   logic [W-1:0] q;
   logic [2:0] index;
   logic wrap;
   logic illegal;

   int checks = 0;
   int failures = 0;

   logic [W-1:0] m_q;
   logic m_mode;
   logic m_wrap;
   logic m_ill;
   logic m_valid = 1'b0;
   logic inject = 1'b0;

   multi_mode_shift_counter #(.WIDTH(W)) dut (
      .clock(clock), .reset(reset), .enable(enable), .mode(mode), .dir(dir),
      .load(load), .load_value(load_value), .q(q), .index(index), .wrap(wrap), .illegal(illegal)
   );

   always #5 clock = ~clock;

   // The model walks an explicit list of sequence values: position p maps to a q pattern
   function automatic int seq_len(input logic m);
      return m ? W : 2 * W;
   endfunction

   function automatic logic [W-1:0] seq_q(input logic m, input int p);
      if (m) return W'(1 << p);
      if (p <= W) return W'((1 << p) - 1);
      return W'(~((1 << (p - W)) - 1));
   endfunction

   function automatic int seq_pos(input logic m, input logic [W-1:0] v);
      for (int p = 0; p < seq_len(m); p++)
         if (seq_q(m, p) == v) return p;
      return -1;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clock) begin : model
      logic [W-1:0] cur;
      int p;
      int n;
      cur = inject ? 4'b0110 : m_q;
      if (reset) begin
         m_q <= seq_q(mode, 0);
         m_mode <= mode;
         m_wrap <= 1'b0;
         m_ill <= 1'b0;
         m_valid <= 1'b1;
      end else begin
         m_wrap <= 1'b0;
         m_ill <= 1'b0;
         if (load) begin
            m_mode <= mode;
            if (seq_pos(mode, load_value) >= 0) m_q <= load_value;
            else begin
               m_q <= seq_q(mode, 0);
               m_ill <= 1'b1;
            end
         end else if (mode != m_mode) begin
            m_mode <= mode;
            m_q <= seq_q(mode, 0);
         end else if (enable) begin
            p = seq_pos(m_mode, cur);
            n = seq_len(m_mode);
            if (p < 0) begin
               m_q <= seq_q(m_mode, 0);
               m_ill <= 1'b1;
            end else if (dir) begin
               m_q <= seq_q(m_mode, (p + n - 1) % n);
               m_wrap <= p == 0;
            end else begin
               m_q <= seq_q(m_mode, (p + 1) % n);
               m_wrap <= p == n - 1;
            end
         end
      end
   end

   always @(negedge clock) begin
      if (m_valid && !inject) begin
         chk("model_q", int'(q), int'(m_q));
         chk("model_index", int'(index), seq_pos(m_mode, m_q) < 0 ? 0 : seq_pos(m_mode, m_q));
         chk("model_wrap", int'(wrap), int'(m_wrap));
         chk("model_illegal", int'(illegal), int'(m_ill));
      end
   end

   task automatic drive(input logic r, input logic m, input logic e, input logic d,
                        input logic l, input logic [W-1:0] lv);
      reset = r;
      mode = m;
      enable = e;
      dir = d;
      load = l;
      load_value = lv;
      @(posedge clock);
      @(negedge clock);
   endtask

   logic [W-1:0] jseq [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};

   initial begin
      drive(1, 0, 0, 0, 0, 0);
      chk("reset_q", int'(q), 0);
      chk("reset_wrap", int'(wrap), 0);
      chk("reset_illegal", int'(illegal), 0);
      for (int i = 0; i < 8; i++) begin
         drive(0, 0, 1, 0, 0, 0);
         chk("johnson_up_q", int'(q), int'(jseq[i]));
         chk("johnson_up_index", int'(index), (i + 1) % 8);
         chk("johnson_up_wrap", int'(wrap), i == 7 ? 1 : 0);
      end
      drive(0, 1, 1, 0, 0, 0);
      chk("to_ring_q", int'(q), 1);
      chk("to_ring_wrap", int'(wrap), 0);
      drive(0, 1, 1, 1, 0, 0);
      chk("ring_down_wrap_q", int'(q), 8);
      chk("ring_down_wrap", int'(wrap), 1);
      chk("ring_down_index", int'(index), 3);
      drive(0, 1, 1, 1, 0, 0);
      chk("ring_down_q2", int'(q), 4);
      chk("ring_down_wrap2", int'(wrap), 0);
      drive(0, 1, 1, 1, 0, 0);
      drive(0, 1, 1, 1, 0, 0);
      chk("ring_down_q4", int'(q), 1);
      drive(0, 1, 1, 0, 0, 0);
      drive(0, 1, 1, 0, 0, 0);
      chk("ring_up_q", int'(q), 4);
      drive(0, 1, 1, 1, 0, 0);
      chk("reverse_q", int'(q), 2);
      drive(0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 1, 4'b0101);
      chk("bad_load_q", int'(q), 0);
      chk("bad_load_illegal", int'(illegal), 1);
      drive(0, 0, 0, 0, 0, 0);
      chk("illegal_pulse_end", int'(illegal), 0);
      drive(0, 0, 1, 0, 1, 4'b0011);
      chk("load_q", int'(q), 3);
      chk("load_index", int'(index), 2);
      drive(0, 0, 1, 0, 0, 0);
      chk("pre_switch_q", int'(q), 7);
      drive(0, 1, 1, 0, 0, 0);
      chk("switch_q", int'(q), 1);
      chk("switch_index", int'(index), 0);
      chk("switch_wrap", int'(wrap), 0);
      drive(0, 1, 1, 0, 0, 0);
      chk("resume_q", int'(q), 2);
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) drive(0, 0, 1, 0, 0, 0);
      chk("at_1110_q", int'(q), 14);
      chk("at_1110_index", int'(index), 5);
      drive(1, 0, 1, 0, 1, 4'b0011);
      chk("reset_override_q", int'(q), 0);
      chk("reset_override_wrap", int'(wrap), 0);
      chk("reset_override_illegal", int'(illegal), 0);
      drive(0, 1, 0, 0, 0, 0);
      inject = 1'b1;
      force dut.q = 4'b0110;
      #1 release dut.q;
      #1 chk("forced_index", int'(index), 0);
      enable = 1'b1;
      @(posedge clock);
      #1 inject = 1'b0;
      @(negedge clock);
      chk("corrected_q", int'(q), 1);
      chk("corrected_illegal", int'(illegal), 1);
      for (int i = 0; i < 600; i++) begin
         logic m;
         m = $urandom_range(0, 9) == 0 ? ~mode : mode;
         drive($urandom_range(0, 49) == 0, m, $urandom_range(0, 3) != 0, 1'($urandom),
               $urandom_range(0, 7) == 0,
               $urandom_range(0, 1) ? seq_q(m, $urandom_range(0, seq_len(m) - 1)) : W'($urandom));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
